// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues in-order imem reads for the current PC,
// pairs each returned word with its PC and queues the pairs for decode.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned PCs produce a faulting
// NOP entry instead of a memory request).
module if_fetch_unit #(
   parameter int DEPTH   = 2,
   parameter int MAX_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic        pc_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_fault,
   input  logic        decode_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + MAX_LAT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          rst_q;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] kill;
   logic [CW-1:0] occ;
   logic [CW-1:0] pcq_cnt;
   logic [AW-1:0] pcq_wr;
   logic [AW-1:0] pcq_rd;
   logic [AW-1:0] f_wr;
   logic [AW-1:0] f_rd;
   logic [31:0]   pcq_mem [DEPTH];
   logic [31:0]   f_instr [DEPTH];
   logic [31:0]   f_pc    [DEPTH];
   logic          f_fault [DEPTH];

   logic          hold;
   logic [CW:0]   inflight;
   logic          credit;
   logic          mis;
   logic          trap_push;
   logic          fire;
   logic          resp_ok;
   logic          resp_accept;
   logic          f_push;
   logic          f_pop;
   logic [31:0]   f_push_instr;
   logic [31:0]   f_push_pc;
   logic          f_push_fault;

   // Request credit, stall, response qualification and registered-head outputs
   always_comb begin
      hold     = rst | rst_q;
      inflight = {1'b0, occ} + {1'b0, outstanding};
      credit   = inflight < {1'b0, DEPTH_C};
`ifdef MISALIGN_TRAP_EN
      mis      = (pc[1:0] != 2'b00);
`else
      mis      = 1'b0;
`endif
      imem_req    = !hold && !flush && credit && !mis;
      // A trap entry waits for the PC queue to drain so it cannot overtake
      // older responses still in flight.
      trap_push   = !hold && !flush && credit && mis && (pcq_cnt == '0);
      fire        = imem_req && imem_gnt;
      pc_stall    = !(fire || trap_push);
      imem_addr   = hold ? 32'h0 : {pc[31:2], 2'b00};

      resp_ok      = imem_rvalid && (outstanding != '0);
      resp_accept  = resp_ok && (kill == '0) && !flush && !rst;
      f_push       = resp_accept || trap_push;
      f_push_instr = resp_accept ? imem_rdata : NOP;
      f_push_pc    = resp_accept ? pcq_mem[pcq_rd] : pc;
      f_push_fault = trap_push;

      instr_valid = !rst && (occ != '0);
      instr       = instr_valid ? f_instr[f_rd] : 32'h0;
      instr_pc    = instr_valid ? f_pc[f_rd]    : 32'h0;
      instr_fault = instr_valid && f_fault[f_rd];
      f_pop       = instr_valid && decode_ready;
   end

   // Outputs stay quiet for one extra cycle after reset is released
   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   // Counters and queue pointers; flush drops queued work and arms the kill count
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding <= '0;
         kill        <= '0;
         occ         <= '0;
         pcq_cnt     <= '0;
         pcq_wr      <= '0;
         pcq_rd      <= '0;
         f_wr        <= '0;
         f_rd        <= '0;
      end else if (flush) begin
         // Every request still owed a response must be dropped; a response
         // arriving right now is already accounted for.
         outstanding <= outstanding - CW'(resp_ok);
         kill        <= outstanding - CW'(resp_ok);
         occ         <= '0;
         pcq_cnt     <= '0;
         pcq_wr      <= '0;
         pcq_rd      <= '0;
         f_wr        <= '0;
         f_rd        <= '0;
      end else begin
         outstanding <= outstanding + CW'(fire) - CW'(resp_ok);
         if (resp_ok && (kill != '0))
            kill <= kill - CW'(1);
         if (fire)
            pcq_wr <= pcq_wr + AW'(1);
         if (resp_accept)
            pcq_rd <= pcq_rd + AW'(1);
         pcq_cnt <= pcq_cnt + CW'(fire) - CW'(resp_accept);
         if (f_push)
            f_wr <= f_wr + AW'(1);
         if (f_pop)
            f_rd <= f_rd + AW'(1);
         occ <= occ + CW'(f_push) - CW'(f_pop);
      end
   end

   // Queue storage; entries are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (fire)
         pcq_mem[pcq_wr] <= {pc[31:2], 2'b00};
      if (f_push) begin
         f_instr[f_wr] <= f_push_instr;
         f_pc[f_wr]    <= f_push_pc;
         f_fault[f_wr] <= f_push_fault;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(f_push && !f_pop && (occ == DEPTH_C)));

   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
      !(imem_rvalid && (outstanding == '0)));

endmodule
